// File: rtl/pc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pc_pkg
// Description : Shared constants and next-PC select encoding for the fetch
//               stage program counter.
// Revision    : 1.0 - initial release
// ============================================================================
package pc_pkg;

    // Every instruction is one 32-bit word, so sequential fetch steps by 4.
    localparam int INSTR_BYTES = 4;

    // Next-PC source, listed from highest to lowest priority.
    typedef enum logic [2:0] {
        SEL_TRAP   = 3'd0,
        SEL_BRANCH = 3'd1,
        SEL_HOLD   = 3'd2,
        SEL_RET    = 3'd3,
        SEL_SEQ    = 3'd4
    } pc_sel_e;

endpackage : pc_pkg
`default_nettype wire

// File: rtl/return_addr_stack.sv
`default_nettype none
// ============================================================================
// Module      : return_addr_stack
// Description : Circular return-address stack. Pushing onto a full stack
//               overwrites the oldest entry; push and pop in the same cycle
//               replace the top entry in place.
// Revision    : 1.0 - initial release
// ============================================================================
module return_addr_stack
    import pc_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top,
    output logic             empty,
    output logic             full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] top_ptr_q, top_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             wr_en;
    logic [PTR_W-1:0] wr_idx;
    logic             do_pop;

    assign empty  = (count_q == '0);
    assign full   = (count_q == CNT_W'(DEPTH));
    assign top    = mem_q[top_ptr_q];
    // A pop on an empty stack has nothing to remove and is dropped.
    assign do_pop = pop & ~empty;

    // Pointer/count next state and the single write port for this cycle.
    always_comb begin
        top_ptr_d = top_ptr_q;
        count_d   = count_q;
        wr_en     = 1'b0;
        wr_idx    = top_ptr_q;
        if (clear) begin
            top_ptr_d = '0;
            count_d   = '0;
        end else if (push && do_pop) begin
            wr_en = 1'b1;
        end else if (push) begin
            top_ptr_d = top_ptr_q + PTR_W'(1);
            wr_idx    = top_ptr_q + PTR_W'(1);
            wr_en     = 1'b1;
            if (!full) begin
                count_d = count_q + CNT_W'(1);
            end
        end else if (do_pop) begin
            top_ptr_d = top_ptr_q - PTR_W'(1);
            count_d   = count_q - CNT_W'(1);
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            top_ptr_q <= '0;
            count_q   <= '0;
        end else begin
            top_ptr_q <= top_ptr_d;
            count_q   <= count_d;
        end
    end

    // Entry storage; contents are only read while count is non-zero.
    always_ff @(posedge clk) begin
        if (wr_en && !reset) begin
            mem_q[wr_idx] <= push_data;
        end
    end

endmodule : return_addr_stack
`default_nettype wire

// File: rtl/pc_unit.sv
`default_nettype none
// ============================================================================
// Module      : pc_unit
// Description : Fetch-stage program counter. Chooses trap vector, resolved
//               branch, RAS-predicted return or PC+4 each cycle, honours
//               stall and flags misaligned branch targets. All outputs are
//               registered.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_unit
    import pc_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int              RAS_DEPTH    = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    input  logic            trap_taken,
    input  logic [XLEN-1:0] trap_vector,
    input  logic            is_call,
    input  logic            is_ret,
    output logic [XLEN-1:0] pc,
    output logic            misaligned,
    output logic            ras_empty,
    output logic            ras_full
);

    logic [XLEN-1:0] pc_q, pc_d;
    logic            misaligned_q, misaligned_d;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] ras_top;
    logic            ras_push;
    logic            ras_pop;
    logic            ras_clear;
    pc_sel_e         pc_sel;
    logic            unused_trap_lsbs;

    // The trap vector is always word-aligned on use, so its low bits are dropped.
    assign unused_trap_lsbs = ^trap_vector[1:0];

    assign pc_plus4 = pc_q + XLEN'(INSTR_BYTES);

    // Priority encoder for the next-PC source.
    always_comb begin
        pc_sel = SEL_SEQ;
        if (trap_taken) begin
            pc_sel = SEL_TRAP;
        end else if (branch_taken) begin
            pc_sel = SEL_BRANCH;
        end else if (stall) begin
            pc_sel = SEL_HOLD;
        end else if (is_ret && !ras_empty) begin
            pc_sel = SEL_RET;
        end
    end

    // Predecode hints only touch the RAS when the fetch actually advances.
    assign ras_clear = (pc_sel == SEL_TRAP);
    assign ras_pop   = (pc_sel == SEL_RET);
    assign ras_push  = is_call && ((pc_sel == SEL_RET) || (pc_sel == SEL_SEQ));

    // Next-PC mux and misaligned-target detection.
    always_comb begin
        pc_d         = pc_q;
        misaligned_d = 1'b0;
        case (pc_sel)
            SEL_TRAP:   pc_d = {trap_vector[XLEN-1:2], 2'b00};
            SEL_BRANCH: begin
                pc_d         = {branch_target[XLEN-1:2], 2'b00};
                misaligned_d = |branch_target[1:0];
            end
            SEL_HOLD:   pc_d = pc_q;
            SEL_RET:    pc_d = ras_top;
            SEL_SEQ:    pc_d = pc_plus4;
            default:    pc_d = pc_plus4;
        endcase
    end

    // PC and misaligned-pulse registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q         <= RESET_VECTOR;
            misaligned_q <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            misaligned_q <= misaligned_d;
        end
    end

    return_addr_stack #(
        .DEPTH (RAS_DEPTH),
        .WIDTH (XLEN)
    ) u_ras (
        .clk       (clk),
        .reset     (reset),
        .clear     (ras_clear),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (pc_plus4),
        .top       (ras_top),
        .empty     (ras_empty),
        .full      (ras_full)
    );

    assign pc         = pc_q;
    assign misaligned = misaligned_q;

endmodule : pc_unit
`default_nettype wire
